// File: rtl/clock_pkg.sv
// Shared types for the four-phase clock source: phase and state enums plus
// the P/Q/R line encoding of each phase.
package clock_pkg;

    typedef enum logic [1:0] {
        PH_W = 2'd0,
        PH_X = 2'd1,
        PH_Y = 2'd2,
        PH_Z = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_RUN_W = 3'd1,
        ST_RUN_X = 3'd2,
        ST_RUN_Y = 3'd3,
        ST_RUN_Z = 3'd4
    } state_t;

    // {P,Q,R}; adjacent phases differ in P plus exactly one of Q or R.
    localparam logic [2:0] PQR_W = 3'b101;
    localparam logic [2:0] PQR_X = 3'b011;
    localparam logic [2:0] PQR_Y = 3'b110;
    localparam logic [2:0] PQR_Z = 3'b000;

    function automatic phase_t phase_of(input state_t s);
        case (s)
            ST_RUN_W: return PH_W;
            ST_RUN_X: return PH_X;
            ST_RUN_Y: return PH_Y;
            default:  return PH_Z;
        endcase
    endfunction

    function automatic logic [2:0] pqr_of(input phase_t p);
        case (p)
            PH_W:    return PQR_W;
            PH_X:    return PQR_X;
            PH_Y:    return PQR_Y;
            default: return PQR_Z;
        endcase
    endfunction

endpackage

// File: rtl/phase_tick_counter.sv
// Modulo-PHASE_TICKS up-counter with enable and clear; tc flags the last
// tick of a phase while enabled.
module phase_tick_counter #(
    parameter int PHASE_TICKS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_TICKS - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_phase_generator.sv
// Four-phase (W/X/Y/Z) clock source: sequences registered P/Q/R phase-select
// lines and the BOP run gate. Define CLOCK_PHASE_MONITOR_EN for feedback checks.
//
// state    | meaning
// ST_STOP  | idle, BOP low, lines parked at Z encoding, RUN sampled every CLK
// ST_RUN_W | W phase, PHASE_TICKS CLKs
// ST_RUN_X | X phase
// ST_RUN_Y | Y phase
// ST_RUN_Z | Z phase; RUN sampled on the last tick to continue or stop
module clock_phase_generator
    import clock_pkg::*;
#(
    parameter int PHASE_TICKS = 4,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       RUN,
`ifdef CLOCK_PHASE_MONITOR_EN
    input  logic       WDA,
    input  logic       XDA,
    input  logic       YDA,
    input  logic       ZDA,
    output logic       PHASE_ERR,
`endif
    output logic       BOP,
    output logic       CGPP,
    output logic       CGPPN,
    output logic       CGQP,
    output logic       CGQPN,
    output logic       CGRP,
    output logic       CGRPN,
    output logic [1:0] PHASE,
    output logic       CYCLE_STB,
    output logic       RUNNING
);

    // Strobe is registered, so it is armed one tick before Z's last tick.
    localparam logic [CNT_W-1:0] STB_ARM = CNT_W'(PHASE_TICKS - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_tc;
    logic [2:0]       pqr_nxt;

    phase_tick_counter #(
        .PHASE_TICKS(PHASE_TICKS),
        .CNT_W      (CNT_W)
    ) u_tick (
        .clk  (CLK),
        .rst_n(RSTN),
        .en   (state != ST_STOP),
        .clr  (state == ST_STOP),
        .cnt  (tick_cnt),
        .tc   (tick_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP:  if (RUN)     state_nxt = ST_RUN_W;
            ST_RUN_W: if (tick_tc) state_nxt = ST_RUN_X;
            ST_RUN_X: if (tick_tc) state_nxt = ST_RUN_Y;
            ST_RUN_Y: if (tick_tc) state_nxt = ST_RUN_Z;
            ST_RUN_Z: if (tick_tc) state_nxt = RUN ? ST_RUN_W : ST_STOP;
            default:               state_nxt = ST_STOP;
        endcase
    end

    assign pqr_nxt = pqr_of(phase_of(state_nxt));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state                  <= ST_STOP;
            PHASE                  <= PH_Z;
            {CGPP, CGQP, CGRP}     <= PQR_Z;
            {CGPPN, CGQPN, CGRPN}  <= ~PQR_Z;
            BOP                    <= 1'b0;
            RUNNING                <= 1'b0;
            CYCLE_STB              <= 1'b0;
        end else begin
            state                  <= state_nxt;
            PHASE                  <= phase_of(state_nxt);
            {CGPP, CGQP, CGRP}     <= pqr_nxt;
            {CGPPN, CGQPN, CGRPN}  <= ~pqr_nxt;
            BOP                    <= (state_nxt != ST_STOP);
            RUNNING                <= (state_nxt != ST_STOP);
            CYCLE_STB              <= (state == ST_RUN_Z) && (tick_cnt == STB_ARM);
        end
    end

`ifdef CLOCK_PHASE_MONITOR_EN
    logic [3:0] fb;
    logic       fb_bad;

    assign fb = {ZDA, YDA, XDA, WDA};

    // Tick 0 of each phase is skipped to tolerate driver delay.
    always_comb begin
        fb_bad = 1'b0;
        if (state == ST_STOP)
            fb_bad = |fb;
        else if (tick_cnt != '0)
            fb_bad = (fb != (4'b0001 << PHASE));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            PHASE_ERR <= 1'b0;
        else if (fb_bad)
            PHASE_ERR <= 1'b1;
    end
`endif

endmodule
